inst_cache: RTL and testbench
=============================

# inst_cache

Two-way set-associative, read-only instruction cache between the multi-cycle RISC-V core's instruction fetch channel and the memory read port. Accepts one fetch per handshake and returns the 32-bit instruction word from a hit or after an 8-beat burst line refill. Exports hit and miss counts for the core's performance counters.

## Interface
- SETS, 8, number of sets; power of two.
- LINE_WORDS, 8, 32-bit words per line; power of two; sets the burst length.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- from_cpu_inst_req_valid  in  1  fetch request valid
- from_cpu_inst_req_addr  in  32  fetch byte address, word-aligned
- to_cpu_inst_req_ready  out  1  request accepted when valid&ready
- to_cpu_cache_rsp_valid  out  1  instruction word valid
- to_cpu_cache_rsp_data  out  32  instruction word
- from_cpu_cache_rsp_ready  in  1  core accepts word
- to_mem_rd_req_valid  out  1  line read request valid
- to_mem_rd_req_addr  out  32  line-aligned byte address
- to_mem_rd_req_len  out  8  beats minus 1, constant LINE_WORDS-1
- from_mem_rd_req_ready  in  1  memory accepts request
- from_mem_rd_rsp_valid  in  1  burst beat valid
- from_mem_rd_rsp_data  in  32  burst beat, ascending word order
- from_mem_rd_rsp_last  in  1  final beat
- to_mem_rd_rsp_ready  out  1  cache accepts beat
- hit_cnt  out  32  completed hit responses
- miss_cnt  out  32  completed refills

## Operation
- Address split, defaults: offset [4:0], word select [4:2], index [7:5], tag [31:8]. Widths derive from SETS and LINE_WORDS.
- Storage: per way and set, one valid bit, one tag, and one line of flops. Per set, one LRU bit that names the victim way.
- States: IDLE, LOOKUP, HIT_RSP, MISS_REQ, REFILL, MISS_RSP.
- IDLE: req_ready=1. On a handshake, latch the address and go to LOOKUP.
- LOOKUP: compare both ways.
  - Hit in way w: set lru[index]=~w and go to HIT_RSP.
  - Miss: choose the victim (way 0 if invalid, else way 1 if invalid, else the way named by lru) and go to MISS_REQ.
- HIT_RSP: rsp_valid=1 with the stored word. Hold until rsp_ready, then increment hit_cnt and return to IDLE.
- MISS_REQ: mem_req_valid=1, addr = {tag,index,5'b0}. Hold until mem_req_ready, then go to REFILL.
- REFILL: mem_rsp_ready=1.
  - Each valid beat writes line buffer word[beat_cnt], then beat_cnt++.
  - On the beat with last=1, write the buffer into the victim way, set valid, write the tag, set lru[index]=~victim, clear beat_cnt, and go to MISS_RSP.
- MISS_RSP: rsp_valid=1 with buffer word[word select]. Hold until rsp_ready, then increment miss_cnt and return to IDLE.
- The line is installed before the response, so a repeat fetch of the same line hits.
- No write path and no invalidate. Instruction memory is read-only.

## Timing
- Reset: state IDLE. All valid bits, LRU bits, beat_cnt, hit_cnt and miss_cnt cleared. Every output 0 except to_cpu_inst_req_ready=1 and to_mem_rd_req_len=LINE_WORDS-1. Data and tag flops are not reset.
- rst during MISS_REQ or REFILL: the refill is abandoned and no valid bit is set. The memory model must also be reset.
- Hit latency: request handshake at cycle T, LOOKUP at T+1, rsp_valid at T+2.
- Miss latency: rsp_valid rises one cycle after the last beat is accepted.
- Held outputs: rsp_valid/rsp_data stay stable until rsp_ready. mem_req_valid/mem_req_addr stay stable until mem_req_ready. A beat is consumed only on valid&ready.
- req_ready is 0 in every state except IDLE. The next request is accepted no earlier than the cycle after the response handshake.
- last must coincide with beat LINE_WORDS-1. A mismatch is a protocol error and is not handled.
- Counters wrap modulo 2^32.

## Structure
- Shared package holds the state encoding, the field-width localparams derived from SETS and LINE_WORDS, and the burst length constant.
- One natural sub-module is inst_cache_way: tag/valid/data storage for one way, with a combinational read and a full-line write port. The top instantiates two and owns the FSM, LRU, buffer and counters.

## Test plan
- Cold miss: fetch 0x0000_0104 with memory word at byte address A equal to A → one burst, addr 0x0000_0100, len 7. The response is 0x0000_0104, miss_cnt=1.
- Hit after fill: then fetch 0x0000_011C → response 0x0000_011C at T+2, no memory request, hit_cnt=1.
- Eviction/LRU: fill set 0 with 0x000, then 0x100, then re-fetch 0x000 (hit), then fetch 0x200 → the 0x100 line is evicted, a later 0x000 fetch hits and a 0x100 fetch misses.
- Backpressure:
  - mem_req_ready low 5 cycles → req_valid and addr held.
  - rsp_valid toggling during the burst → beats stored in order.
  - rsp_ready low 3 cycles → data held.
- Reset mid-refill: assert rst after beat 3 → all outputs at reset values. A subsequent fetch of the same address misses and refills.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// Shared definitions for the two-way instruction cache: default geometry,
// derived address-field widths and the controller state encoding.
package inst_cache_pkg;

  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned WORD_W           = 32;
  localparam int unsigned LEN_W            = 8;
  localparam int unsigned CACHE_SETS       = 8;
  localparam int unsigned CACHE_LINE_WORDS = 8;

  localparam int unsigned INDEX_W   = $clog2(CACHE_SETS);
  localparam int unsigned WSEL_W    = $clog2(CACHE_LINE_WORDS);
  localparam int unsigned OFFSET_W  = WSEL_W + 2;
  localparam int unsigned TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned BURST_LEN = CACHE_LINE_WORDS - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_HIT_RSP,
    ST_MISS_REQ,
    ST_REFILL,
    ST_MISS_RSP
  } state_e;

endpackage

// File: rtl/inst_cache_way.sv
// One cache way: per-set valid bit, tag and line storage with a
// combinational word read and a full-line write port.
module inst_cache_way
  import inst_cache_pkg::*;
#(
  parameter int unsigned SETS       = CACHE_SETS,
  parameter int unsigned LINE_WORDS = CACHE_LINE_WORDS,
  parameter int unsigned TAG_BITS   = TAG_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [$clog2(SETS)-1:0]             rd_index,
  input  logic [$clog2(LINE_WORDS)-1:0]       rd_wsel,
  output logic                                rd_valid_c,
  output logic [TAG_BITS-1:0]                 rd_tag_c,
  output logic [WORD_W-1:0]                   rd_word_c,
  input  logic                                wr_en,
  input  logic [$clog2(SETS)-1:0]             wr_index,
  input  logic [TAG_BITS-1:0]                 wr_tag,
  input  logic [LINE_WORDS-1:0][WORD_W-1:0]   wr_line
);

  logic [SETS-1:0]                 valid_q;
  logic [TAG_BITS-1:0]             tag_q  [SETS];
  logic [LINE_WORDS-1:0][WORD_W-1:0] data_q [SETS];

  // Only the valid bits are reset; tag and data are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end
  end

  assign rd_valid_c = valid_q[rd_index];
  assign rd_tag_c   = tag_q[rd_index];
  assign rd_word_c  = data_q[rd_index][rd_wsel];

endmodule

// File: rtl/inst_cache.sv
// Two-way set-associative read-only instruction cache with LRU replacement
// and burst line refill; exports hit and refill counts.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned SETS       = CACHE_SETS,
  parameter int unsigned LINE_WORDS = CACHE_LINE_WORDS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                from_cpu_inst_req_valid,
  input  logic [ADDR_W-1:0]   from_cpu_inst_req_addr,
  output logic                to_cpu_inst_req_ready,
  output logic                to_cpu_cache_rsp_valid,
  output logic [WORD_W-1:0]   to_cpu_cache_rsp_data,
  input  logic                from_cpu_cache_rsp_ready,
  output logic                to_mem_rd_req_valid,
  output logic [ADDR_W-1:0]   to_mem_rd_req_addr,
  output logic [LEN_W-1:0]    to_mem_rd_req_len,
  input  logic                from_mem_rd_req_ready,
  input  logic                from_mem_rd_rsp_valid,
  input  logic [WORD_W-1:0]   from_mem_rd_rsp_data,
  input  logic                from_mem_rd_rsp_last,
  output logic                to_mem_rd_rsp_ready,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
);

  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned WS_W   = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = WS_W + 2;
  localparam int unsigned TAG_BW = ADDR_W - IDX_W - OFF_W;

  state_e state_q, state_d;

  logic [TAG_BW-1:0]                 tag_q;
  logic [IDX_W-1:0]                  index_q;
  logic [WS_W-1:0]                   wsel_q;
  logic                              victim_q;
  logic [SETS-1:0]                   lru_q;
  logic [WS_W-1:0]                   beat_cnt_q;
  logic [LINE_WORDS-1:0][WORD_W-1:0] buf_q;
  logic [LINE_WORDS-1:0][WORD_W-1:0] fill_line;

  logic                req_ready_d, rsp_valid_d, mem_req_valid_d, mem_rsp_ready_d;
  logic [WORD_W-1:0]   rsp_data_d;
  logic [ADDR_W-1:0]   mem_req_addr_d;

  logic                w0_valid, w1_valid;
  logic [TAG_BW-1:0]   w0_tag, w1_tag;
  logic [WORD_W-1:0]   w0_word, w1_word;
  logic                hit0, hit1, miss_victim;
  logic                req_fire, rsp_fire, mreq_fire, beat_fire, last_fire;
  logic                way_wr0, way_wr1;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs  = ^from_cpu_inst_req_addr[1:0];
  assign to_mem_rd_req_len = LEN_W'(LINE_WORDS - 1);

  assign req_fire  = from_cpu_inst_req_valid && to_cpu_inst_req_ready;
  assign rsp_fire  = to_cpu_cache_rsp_valid && from_cpu_cache_rsp_ready;
  assign mreq_fire = to_mem_rd_req_valid && from_mem_rd_req_ready;
  assign beat_fire = from_mem_rd_rsp_valid && to_mem_rd_rsp_ready;
  assign last_fire = beat_fire && from_mem_rd_rsp_last;

  assign hit0 = w0_valid && (w0_tag == tag_q);
  assign hit1 = w1_valid && (w1_tag == tag_q);
  assign miss_victim = !w0_valid ? 1'b0 : (!w1_valid ? 1'b1 : lru_q[index_q]);

  assign way_wr0 = (state_q == ST_REFILL) && last_fire && !victim_q;
  assign way_wr1 = (state_q == ST_REFILL) && last_fire &&  victim_q;

  // Buffer with the in-flight beat merged, so the last beat can be installed
  // and forwarded in the same cycle it arrives.
  always_comb begin
    fill_line = buf_q;
    fill_line[beat_cnt_q] = from_mem_rd_rsp_data;
  end

  inst_cache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_BITS(TAG_BW)) u_way0 (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (index_q),
    .rd_wsel    (wsel_q),
    .rd_valid_c (w0_valid),
    .rd_tag_c   (w0_tag),
    .rd_word_c  (w0_word),
    .wr_en      (way_wr0),
    .wr_index   (index_q),
    .wr_tag     (tag_q),
    .wr_line    (fill_line)
  );

  inst_cache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_BITS(TAG_BW)) u_way1 (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (index_q),
    .rd_wsel    (wsel_q),
    .rd_valid_c (w1_valid),
    .rd_tag_c   (w1_tag),
    .rd_word_c  (w1_word),
    .wr_en      (way_wr1),
    .wr_index   (index_q),
    .wr_tag     (tag_q),
    .wr_line    (fill_line)
  );

  // Next state and next values of the registered handshake outputs.
  always_comb begin
    state_d         = state_q;
    req_ready_d     = 1'b0;
    rsp_valid_d     = 1'b0;
    rsp_data_d      = to_cpu_cache_rsp_data;
    mem_req_valid_d = 1'b0;
    mem_req_addr_d  = to_mem_rd_req_addr;
    mem_rsp_ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) state_d = ST_LOOKUP;
        else          req_ready_d = 1'b1;
      end
      ST_LOOKUP: begin
        if (hit0 || hit1) begin
          state_d     = ST_HIT_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = hit0 ? w0_word : w1_word;
        end else begin
          state_d         = ST_MISS_REQ;
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = {tag_q, index_q, {OFF_W{1'b0}}};
        end
      end
      ST_HIT_RSP, ST_MISS_RSP: begin
        if (rsp_fire) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      ST_MISS_REQ: begin
        if (mreq_fire) begin
          state_d         = ST_REFILL;
          mem_rsp_ready_d = 1'b1;
        end else begin
          mem_req_valid_d = 1'b1;
        end
      end
      ST_REFILL: begin
        if (last_fire) begin
          state_d     = ST_MISS_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = fill_line[wsel_q];
        end else begin
          mem_rsp_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                <= ST_IDLE;
      to_cpu_inst_req_ready  <= 1'b1;
      to_cpu_cache_rsp_valid <= 1'b0;
      to_cpu_cache_rsp_data  <= '0;
      to_mem_rd_req_valid    <= 1'b0;
      to_mem_rd_req_addr     <= '0;
      to_mem_rd_rsp_ready    <= 1'b0;
    end else begin
      state_q                <= state_d;
      to_cpu_inst_req_ready  <= req_ready_d;
      to_cpu_cache_rsp_valid <= rsp_valid_d;
      to_cpu_cache_rsp_data  <= rsp_data_d;
      to_mem_rd_req_valid    <= mem_req_valid_d;
      to_mem_rd_req_addr     <= mem_req_addr_d;
      to_mem_rd_rsp_ready    <= mem_rsp_ready_d;
    end
  end

  // Replacement state, beat counter and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      lru_q      <= '0;
      victim_q   <= 1'b0;
      beat_cnt_q <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      if (state_q == ST_LOOKUP) begin
        if (hit0)      lru_q[index_q] <= 1'b1;
        else if (hit1) lru_q[index_q] <= 1'b0;
        else           victim_q       <= miss_victim;
      end
      if (state_q == ST_REFILL && beat_fire) begin
        beat_cnt_q <= last_fire ? '0 : beat_cnt_q + WS_W'(1);
        if (last_fire) lru_q[index_q] <= ~victim_q;
      end
      if (state_q == ST_HIT_RSP && rsp_fire)  hit_cnt  <= hit_cnt + 32'(1);
      if (state_q == ST_MISS_RSP && rsp_fire) miss_cnt <= miss_cnt + 32'(1);
    end
  end

  // Request fields and line buffer carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_q   <= from_cpu_inst_req_addr[ADDR_W-1:OFF_W+IDX_W];
      index_q <= from_cpu_inst_req_addr[OFF_W+IDX_W-1:OFF_W];
      wsel_q  <= from_cpu_inst_req_addr[OFF_W-1:2];
    end
    if (state_q == ST_REFILL && beat_fire) begin
      buf_q[beat_cnt_q] <= from_mem_rd_rsp_data;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: memory word at byte address A holds A, so
// every expected response equals the fetch address.
module tb_inst_cache;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_ready;
  logic        mreq_valid;
  logic [31:0] mreq_addr;
  logic [7:0]  mreq_len;
  logic        mreq_ready;
  logic        beat_valid;
  logic [31:0] beat_data;
  logic        beat_last;
  logic        beat_ready;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  inst_cache dut (
    .clk                      (clk),
    .rst                      (rst),
    .from_cpu_inst_req_valid  (req_valid),
    .from_cpu_inst_req_addr   (req_addr),
    .to_cpu_inst_req_ready    (req_ready),
    .to_cpu_cache_rsp_valid   (rsp_valid),
    .to_cpu_cache_rsp_data    (rsp_data),
    .from_cpu_cache_rsp_ready (rsp_ready),
    .to_mem_rd_req_valid      (mreq_valid),
    .to_mem_rd_req_addr       (mreq_addr),
    .to_mem_rd_req_len        (mreq_len),
    .from_mem_rd_req_ready    (mreq_ready),
    .from_mem_rd_rsp_valid    (beat_valid),
    .from_mem_rd_rsp_data     (beat_data),
    .from_mem_rd_rsp_last     (beat_last),
    .to_mem_rd_rsp_ready      (beat_ready),
    .hit_cnt                  (hit_cnt),
    .miss_cnt                 (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rst_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rst_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rst_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_rst_mreq_valid"}, 32'(mreq_valid), 32'd0);
    check({tag, "_rst_mreq_addr"}, mreq_addr, 32'd0);
    check({tag, "_rst_len"}, 32'(mreq_len), 32'd7);
    check({tag, "_rst_beat_ready"}, 32'(beat_ready), 32'd0);
    check({tag, "_rst_hit_cnt"}, hit_cnt, 32'd0);
    check({tag, "_rst_miss_cnt"}, miss_cnt, 32'd0);
  endtask

  // One fetch from request to response handshake, acting as core and memory.
  // abort_beat >= 0 pulses rst after that beat is accepted and returns.
  task automatic fetch(input string tag, input logic [31:0] addr, input bit exp_hit,
                       input int req_stall, input bit gaps, input int rsp_stall,
                       input int abort_beat);
    logic [31:0] line;
    line = addr & 32'hFFFF_FFE0;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_busy"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    if (exp_hit) begin
      check({tag, "_hit_latency"}, 32'(rsp_valid), 32'd1);
      check({tag, "_no_mreq"}, 32'(mreq_valid), 32'd0);
    end else begin
      check({tag, "_mreq_valid"}, 32'(mreq_valid), 32'd1);
      check({tag, "_mreq_addr"}, mreq_addr, line);
      check({tag, "_mreq_len"}, 32'(mreq_len), 32'd7);
      repeat (req_stall) begin
        @(negedge clk);
        check({tag, "_mreq_hold_valid"}, 32'(mreq_valid), 32'd1);
        check({tag, "_mreq_hold_addr"}, mreq_addr, line);
      end
      mreq_ready = 1'b1;
      @(negedge clk);
      mreq_ready = 1'b0;
      check({tag, "_beat_ready"}, 32'(beat_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
        if (gaps && (i % 2 == 1)) begin
          beat_valid = 1'b0;
          @(negedge clk);
        end
        beat_valid = 1'b1;
        beat_data  = line + 32'(4 * i);
        beat_last  = (i == 7);
        @(negedge clk);
        if (i == abort_beat) begin
          beat_valid = 1'b0;
          beat_last  = 1'b0;
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          exp_hits   = 0;
          exp_misses = 0;
          check_reset_outputs(tag);
          return;
        end
      end
      beat_valid = 1'b0;
      beat_last  = 1'b0;
      check({tag, "_miss_latency"}, 32'(rsp_valid), 32'd1);
    end
    check({tag, "_data"}, rsp_data, addr);
    repeat (rsp_stall) begin
      @(negedge clk);
      check({tag, "_rsp_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_rsp_hold_data"}, rsp_data, addr);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (exp_hit) exp_hits++;
    else         exp_misses++;
    check({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
    check({tag, "_hit_cnt"}, hit_cnt, 32'(exp_hits));
    check({tag, "_miss_cnt"}, miss_cnt, 32'(exp_misses));
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    rsp_ready  = 1'b0;
    mreq_ready = 1'b0;
    beat_valid = 1'b0;
    beat_data  = '0;
    beat_last  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("init");

    //    tag       addr          hit  rqst gaps rsps abort
    fetch("cold",   32'h0000_0104, 0,   0,   0,   0,   -1);
    fetch("hit",    32'h0000_011C, 1,   0,   0,   0,   -1);
    fetch("m000",   32'h0000_0000, 0,   0,   0,   0,   -1);
    fetch("h100",   32'h0000_0100, 1,   0,   0,   0,   -1);
    fetch("h000",   32'h0000_0000, 1,   0,   0,   0,   -1);
    fetch("bp200",  32'h0000_0200, 0,   5,   1,   3,   -1);
    fetch("h21c",   32'h0000_021C, 1,   0,   0,   0,   -1);
    fetch("h208",   32'h0000_0208, 1,   0,   0,   2,   -1);
    fetch("h000b",  32'h0000_0000, 1,   0,   0,   0,   -1);
    fetch("m100",   32'h0000_0100, 0,   0,   0,   0,   -1);
    fetch("h004",   32'h0000_0004, 1,   0,   0,   0,   -1);
    fetch("m1e4",   32'h0000_01E4, 0,   2,   0,   0,   -1);
    fetch("h1fc",   32'h0000_01FC, 1,   0,   0,   0,   -1);
    fetch("abort",  32'h0000_0304, 0,   0,   0,   0,    3);
    fetch("re304",  32'h0000_0304, 0,   0,   0,   0,   -1);
    fetch("h300",   32'h0000_0300, 1,   0,   0,   0,   -1);
    fetch("m000c",  32'h0000_0010, 0,   0,   1,   1,   -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
